// File: rtl/vmul_pkg.sv
// Shared types for the vector multiplier issue path: latency default,
// requester index and the result FIFO entry layout.
package vmul_pkg;

  localparam int unsigned MUL_LATENCY_DEF = 6;
  localparam int unsigned DATA_WIDTH_DEF  = 64;
  localparam int unsigned ADDR_WIDTH_DEF  = 32;

  typedef logic req_id_t;

  typedef struct packed {
    req_id_t                   id;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } vmul_entry_t;

endpackage

// File: rtl/vmul_issue_ctrl_if.sv
// Requester, multiplier and writeback signals of vmul_issue_ctrl.
// slave is the controller's view, master the surrounding system's view.
interface vmul_issue_ctrl_if #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned SEW_WIDTH   = 2,
  parameter int unsigned OPSEL_WIDTH = 2
);
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [2*DATA_WIDTH-1:0]  req_vec0;
  logic [2*DATA_WIDTH-1:0]  req_vec1;
  logic [2*SEW_WIDTH-1:0]   req_sew;
  logic [2*OPSEL_WIDTH-1:0] req_opsel;
  logic [2*ADDR_WIDTH-1:0]  req_addr;

  logic                     mul_valid;
  logic [DATA_WIDTH-1:0]    mul_vec0;
  logic [DATA_WIDTH-1:0]    mul_vec1;
  logic [SEW_WIDTH-1:0]     mul_sew;
  logic [OPSEL_WIDTH-1:0]   mul_opsel;
  logic [ADDR_WIDTH-1:0]    mul_addr;

  logic                     mul_out_valid;
  logic [DATA_WIDTH-1:0]    mul_out_vec;
  logic [ADDR_WIDTH-1:0]    mul_out_addr;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [DATA_WIDTH-1:0]    resp_data;
  logic [ADDR_WIDTH-1:0]    resp_addr;
  logic                     resp_id;
  logic                     err;

  modport slave (
    input  req_valid, req_vec0, req_vec1, req_sew, req_opsel, req_addr,
    input  mul_out_valid, mul_out_vec, mul_out_addr, resp_ready,
    output req_ready, mul_valid, mul_vec0, mul_vec1, mul_sew, mul_opsel, mul_addr,
    output resp_valid, resp_data, resp_addr, resp_id, err
  );

  modport master (
    output req_valid, req_vec0, req_vec1, req_sew, req_opsel, req_addr,
    output mul_out_valid, mul_out_vec, mul_out_addr, resp_ready,
    input  req_ready, mul_valid, mul_vec0, mul_vec1, mul_sew, mul_opsel, mul_addr,
    input  resp_valid, resp_data, resp_addr, resp_id, err
  );
endinterface

// File: rtl/vmul_result_fifo.sv
// Synchronous result FIFO with occupancy count; head is read from registered
// storage and forced to zero when empty.
module vmul_result_fifo #(
  parameter type         T     = vmul_pkg::vmul_entry_t,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output T                           o_data,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_valid = (r_cnt != '0);
  assign o_count = r_cnt;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & o_valid;

  // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/vmul_issue_ctrl.sv
// Two-lane round-robin issue controller for the shared vector multiplier with
// latency tracking and credit-protected result FIFO. Optional: VMUL_ISSUE_CTRL_FLUSH_EN.
module vmul_issue_ctrl
  import vmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned SEW_WIDTH   = 2,
  parameter int unsigned OPSEL_WIDTH = 2,
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic clk,
  input logic rst,
`ifdef VMUL_ISSUE_CTRL_FLUSH_EN
  input logic flush,
`endif
  vmul_issue_ctrl_if.slave bus
);
  typedef struct packed {
    req_id_t               id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int unsigned OCC_W = $clog2(MUL_LATENCY + FIFO_DEPTH + 1);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);

  req_id_t                r_last;
  logic [MUL_LATENCY-1:0] r_trk_v;
  logic [MUL_LATENCY-1:0] r_trk_id;
  logic                   r_err;

  logic       w_flush;
  logic [1:0] w_win;
  req_id_t    w_sel;
  logic       w_credit_ok;
  logic       w_issue;
  logic       w_tail_v;
  logic       w_ret_exp;
  logic       w_full;
  logic       w_resp_valid;
  logic [FCW-1:0]   w_fifo_cnt;
  logic [OCC_W-1:0] w_occ;
  entry_t     w_wr_entry;
  entry_t     w_head;

`ifdef VMUL_ISSUE_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  always_comb begin
    w_win = 2'b00;
    w_sel = 1'b0;
    case (bus.req_valid)
      2'b01: begin w_win = 2'b01; w_sel = 1'b0; end
      2'b10: begin w_win = 2'b10; w_sel = 1'b1; end
      2'b11: begin w_win = r_last ? 2'b01 : 2'b10; w_sel = ~r_last; end
      default: ;
    endcase
  end

  // Credit uses registered state only: returns and pops free slots next cycle.
  always_comb begin
    w_occ = OCC_W'(w_fifo_cnt);
    for (int unsigned k = 0; k < MUL_LATENCY; k++) w_occ = w_occ + OCC_W'(r_trk_v[k]);
  end

  assign w_credit_ok   = (w_occ < OCC_W'(FIFO_DEPTH)) & ~w_flush;
  assign bus.req_ready = w_win & {2{w_credit_ok}};
  assign w_issue       = |(bus.req_valid & bus.req_ready);
  assign bus.mul_valid = w_issue;

  always_comb begin
    bus.mul_vec0  = '0;
    bus.mul_vec1  = '0;
    bus.mul_sew   = '0;
    bus.mul_opsel = '0;
    bus.mul_addr  = '0;
    if (w_issue) begin
      bus.mul_vec0  = w_sel ? bus.req_vec0[2*DATA_WIDTH-1:DATA_WIDTH]   : bus.req_vec0[DATA_WIDTH-1:0];
      bus.mul_vec1  = w_sel ? bus.req_vec1[2*DATA_WIDTH-1:DATA_WIDTH]   : bus.req_vec1[DATA_WIDTH-1:0];
      bus.mul_sew   = w_sel ? bus.req_sew[2*SEW_WIDTH-1:SEW_WIDTH]      : bus.req_sew[SEW_WIDTH-1:0];
      bus.mul_opsel = w_sel ? bus.req_opsel[2*OPSEL_WIDTH-1:OPSEL_WIDTH] : bus.req_opsel[OPSEL_WIDTH-1:0];
      bus.mul_addr  = w_sel ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]   : bus.req_addr[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trk_v  <= '0;
      r_trk_id <= '0;
      r_last   <= 1'b1;
    end else begin
      r_trk_v  <= w_flush ? '0 : {r_trk_v[MUL_LATENCY-2:0], w_issue};
      r_trk_id <= {r_trk_id[MUL_LATENCY-2:0], w_sel};
      if (w_issue) r_last <= w_sel;
    end
  end

  assign w_tail_v = r_trk_v[MUL_LATENCY-1];

`ifdef VMUL_ISSUE_CTRL_FLUSH_EN
  // Ops cleared by flush still come back from the multiplier; the mask follows
  // them down the pipe so their returns are expected and discarded.
  logic [MUL_LATENCY-1:0] r_drop;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_drop <= '0;
    else if (w_flush) r_drop <= {r_drop[MUL_LATENCY-2:0] | r_trk_v[MUL_LATENCY-2:0], 1'b0};
    else r_drop <= {r_drop[MUL_LATENCY-2:0], 1'b0};
  end
  assign w_ret_exp = w_tail_v | r_drop[MUL_LATENCY-1];
`else
  assign w_ret_exp = w_tail_v;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if ((bus.mul_out_valid != w_ret_exp) | (w_tail_v & w_full & ~w_flush)) r_err <= 1'b1;
  end

  assign w_wr_entry = '{id: r_trk_id[MUL_LATENCY-1], addr: bus.mul_out_addr, data: bus.mul_out_vec};

  vmul_result_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_flush),
    .i_push  (w_tail_v),
    .i_data  (w_wr_entry),
    .i_pop   (bus.resp_ready),
    .o_valid (w_resp_valid),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_count (w_fifo_cnt)
  );

  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_data  = w_head.data;
  assign bus.resp_addr  = w_head.addr;
  assign bus.resp_id    = w_head.id;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Self-checking bench for vmul_issue_ctrl: a queue-based multiplier and
// scoreboard model drive randomized traffic and check grants and responses.
module tb_vmul_issue_ctrl;
  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fl  = 1'b0;
  always #5 clk = ~clk;

  vmul_issue_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEW_WIDTH(2), .OPSEL_WIDTH(2)) bus ();

  vmul_issue_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEW_WIDTH(2), .OPSEL_WIDTH(2),
    .MUL_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef VMUL_ISSUE_CTRL_FLUSH_EN
    .flush (fl),
`endif
    .bus   (bus)
  );

  typedef struct {
    int unsigned   id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } resp_t;
  typedef struct {
    longint        cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ret_t;
  typedef struct {
    longint        cyc;
    int unsigned   id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } got_t;

  resp_t exp_q[$];
  ret_t  pipe_q[$];
  got_t  got_q[$];

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  int          m_occ = 0;
  int unsigned m_last = 1;
  logic        spur = 1'b0;

  logic [DW-1:0] drv_a [2];
  logic [DW-1:0] drv_b [2];
  logic [AW-1:0] drv_addr [2];
  logic [1:0]    drv_sew [2];
  logic [1:0]    drv_op [2];

  logic [1:0]    e_ready, o_ready;
  logic          e_issue, o_mv;
  logic [DW-1:0] e_mv0, e_mv1, o_mv0, o_mv1;
  logic [AW-1:0] e_maddr, o_maddr;
  logic [1:0]    e_msew, o_msew, e_mop, o_mop;

  task automatic pack();
    bus.req_vec0  = {drv_a[1], drv_a[0]};
    bus.req_vec1  = {drv_b[1], drv_b[0]};
    bus.req_addr  = {drv_addr[1], drv_addr[0]};
    bus.req_sew   = {drv_sew[1], drv_sew[0]};
    bus.req_opsel = {drv_op[1], drv_op[0]};
  endtask

  task automatic drive(input logic [1:0] v);
    for (int i = 0; i < 2; i++) begin
      drv_a[i]    = {$urandom, $urandom};
      drv_b[i]    = {$urandom, $urandom};
      drv_addr[i] = $urandom;
      drv_sew[i]  = 2'($urandom_range(0, 3));
      drv_op[i]   = 2'($urandom_range(0, 3));
    end
    bus.req_valid = v;
    pack();
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drv_a[i] = '0; drv_b[i] = '0; drv_addr[i] = '0; drv_sew[i] = '0; drv_op[i] = '0;
    end
    pack();
    bus.mul_out_valid = 1'b0;
    bus.mul_out_vec   = '0;
    bus.mul_out_addr  = '0;
    bus.resp_ready    = 1'b0;
  endtask

  // One clock cycle: multiplier model, grant model, scoreboard bookkeeping.
  task automatic tick();
    int unsigned sel;
    bit credit;
    if (pipe_q.size() != 0 && pipe_q[0].cyc == cyc) begin
      bus.mul_out_valid = 1'b1;
      bus.mul_out_vec   = pipe_q[0].data;
      bus.mul_out_addr  = pipe_q[0].addr;
      void'(pipe_q.pop_front());
    end else begin
      bus.mul_out_valid = spur;
      bus.mul_out_vec   = '0;
      bus.mul_out_addr  = '0;
    end
    spur = 1'b0;
    #1;
    if (bus.req_valid == 2'b11) sel = (m_last == 0) ? 1 : 0;
    else if (bus.req_valid[1]) sel = 1;
    else sel = 0;
    credit  = (m_occ < DEPTH) && !fl;
    e_issue = (bus.req_valid != 2'b00) && credit;
    e_ready = e_issue ? (2'b01 << sel) : 2'b00;
    e_mv0   = e_issue ? drv_a[sel] : '0;
    e_mv1   = e_issue ? drv_b[sel] : '0;
    e_maddr = e_issue ? drv_addr[sel] : '0;
    e_msew  = e_issue ? drv_sew[sel] : '0;
    e_mop   = e_issue ? drv_op[sel] : '0;
    o_ready = bus.req_ready;
    o_mv    = bus.mul_valid;
    o_mv0   = bus.mul_vec0;
    o_mv1   = bus.mul_vec1;
    o_maddr = bus.mul_addr;
    o_msew  = bus.mul_sew;
    o_mop   = bus.mul_opsel;
    if (e_issue) begin
      exp_q.push_back('{sel, drv_addr[sel], drv_a[sel] * drv_b[sel]});
      m_occ++;
      m_last = sel;
    end
    if (bus.mul_valid) pipe_q.push_back('{cyc + LAT, bus.mul_addr, bus.mul_vec0 * bus.mul_vec1});
    if (fl) begin
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
      m_occ = 0;
    end else if (bus.resp_valid && bus.resp_ready) begin
      got_q.push_back('{cyc, 32'(bus.resp_id), bus.resp_addr, bus.resp_data});
      m_occ--;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b1;
    for (int n = 0; n < 60 && (got_q.size() < exp_q.size() || pipe_q.size() != 0); n++) tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    pipe_q.delete(); exp_q.delete(); got_q.delete();
    m_occ = 0; m_last = 1; spur = 1'b0; fl = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({bus.req_ready, bus.mul_valid, bus.resp_valid, bus.resp_id, bus.err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000", {bus.req_ready, bus.mul_valid, bus.resp_valid, bus.resp_id, bus.err});
    end
    checks++;
    if ({bus.mul_vec0, bus.mul_vec1, bus.mul_addr, bus.mul_sew, bus.mul_opsel} !== '0) begin
      errors++;
      $display("FAIL reset_mul_fields: got %h required 0", {bus.mul_vec0, bus.mul_vec1, bus.mul_addr});
    end
    checks++;
    if ({bus.resp_data, bus.resp_addr} !== '0) begin
      errors++;
      $display("FAIL reset_resp: got %h/%h required 0", bus.resp_data, bus.resp_addr);
    end
    do_reset();
  endtask

  task automatic test_single();
    longint t;
    do_reset();
    bus.resp_ready = 1'b1;
    drive(2'b01);
    drv_a[0] = 64'h1234; drv_b[0] = 64'h1; pack();
    t = cyc;
    tick();
    checks++;
    if (o_ready !== 2'b01 || o_mv !== 1'b1 || o_mv0 !== 64'h1234 || o_maddr !== drv_addr[0]) begin
      errors++;
      $display("FAIL single_issue: ready=%b mv=%b vec0=%h addr=%h required 01 1 1234 %h", o_ready, o_mv, o_mv0, o_maddr, drv_addr[0]);
    end
    bus.req_valid = 2'b00;
    for (int n = 0; n < 12 && got_q.size() == 0; n++) tick();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL single_resp_count: got %0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].cyc != t + LAT + 1 || got_q[0].id != 0 || got_q[0].data !== 64'h1234 || got_q[0].addr !== exp_q[0].addr) begin
        errors++;
        $display("FAIL single_resp: cyc=%0d id=%0d data=%h required cyc=%0d id=0 data=1234", got_q[0].cyc, got_q[0].id, got_q[0].data, t + LAT + 1);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11);
      tick();
      checks++;
      if (o_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10) || o_ready !== e_ready) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got %b required %b", i, o_ready, e_ready);
      end
      checks++;
      if ({o_mv, o_mv0, o_mv1, o_maddr, o_msew, o_mop} !== {e_issue, e_mv0, e_mv1, e_maddr, e_msew, e_mop}) begin
        errors++;
        $display("FAIL contention_fields[%0d]: got %h/%h required %h/%h", i, o_mv0, o_maddr, e_mv0, e_maddr);
      end
    end
    drain();
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL contention_count: got %0d required 6", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].id != (i % 2) || got_q[i].data !== exp_q[i].data || got_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL contention_resp[%0d]: id=%0d data=%h required id=%0d data=%h", i, got_q[i].id, got_q[i].data, i % 2, exp_q[i].data);
      end
    end
  endtask

  task automatic test_backpressure();
    int n_iss;
    int bad;
    do_reset();
    bus.resp_ready = 1'b0;
    n_iss = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(2'($urandom_range(1, 3)));
      tick();
      if (o_mv) n_iss++;
      if (o_ready !== e_ready) bad++;
    end
    checks++;
    if (n_iss != DEPTH || o_ready !== 2'b00 || bad != 0) begin
      errors++;
      $display("FAIL bp_fill: issues=%0d ready=%b grant_errs=%0d required %0d 00 0", n_iss, o_ready, bad, DEPTH);
    end
    bus.resp_ready = 1'b1;
    drive(2'b11);
    tick();
    checks++;
    if (o_mv !== 1'b0 || got_q.size() != 1) begin
      errors++;
      $display("FAIL bp_pop_cycle: mv=%b pops=%0d required 0 1", o_mv, got_q.size());
    end
    bus.resp_ready = 1'b0;
    drive(2'b11);
    tick();
    checks++;
    if (o_mv !== 1'b1) begin
      errors++;
      $display("FAIL bp_credit_return: mv=%b required 1", o_mv);
    end
    n_iss = 0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11);
      tick();
      if (o_mv) n_iss++;
    end
    checks++;
    if (n_iss != 0) begin
      errors++;
      $display("FAIL bp_one_credit: extra issues=%0d required 0", n_iss);
    end
    drain();
    checks++;
    if (got_q.size() != DEPTH + 1) begin
      errors++;
      $display("FAIL bp_count: got %0d required %0d", got_q.size(), DEPTH + 1);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].id != exp_q[i].id || got_q[i].data !== exp_q[i].data || got_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL bp_resp[%0d]: id=%0d data=%h required id=%0d data=%h", i, got_q[i].id, got_q[i].data, exp_q[i].id, exp_q[i].data);
      end
    end
  endtask

  task automatic test_push_pop();
    int n_iss;
    do_reset();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(2'($urandom_range(1, 3))); tick(); end
    bus.req_valid = 2'b00;
    repeat (8) tick();
    drive(2'($urandom_range(1, 3)));
    tick();
    bus.req_valid = 2'b00;
    repeat (LAT - 1) tick();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (got_q.size() != 1 || bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL pushpop_pop: pops=%0d resp_valid=%b required 1 1", got_q.size(), bus.resp_valid);
    end
    n_iss = 0;
    for (int i = 0; i < 10; i++) begin
      drive(2'b11);
      tick();
      if (o_mv) n_iss++;
    end
    checks++;
    if (n_iss != DEPTH - 4) begin
      errors++;
      $display("FAIL pushpop_count: free credits=%0d required %0d", n_iss, DEPTH - 4);
    end
    drain();
    checks++;
    if (got_q.size() != 9) begin
      errors++;
      $display("FAIL pushpop_total: got %0d required 9", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].id != exp_q[i].id || got_q[i].data !== exp_q[i].data || got_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL pushpop_resp[%0d]: id=%0d data=%h required id=%0d data=%h", i, got_q[i].id, got_q[i].data, exp_q[i].id, exp_q[i].data);
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    repeat (2) tick();
    spur = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.err !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_err: err=%b resp_valid=%b required 1 0", bus.err, bus.resp_valid);
    end
    repeat (4) tick();
    checks++;
    if (bus.err !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_sticky: err=%b resp_valid=%b required 1 0", bus.err, bus.resp_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)));
      bus.resp_ready = ($urandom_range(0, 9) < 7);
      tick();
      checks++;
      if (o_ready !== e_ready) begin
        errors++;
        $display("FAIL random_ready[%0d]: got %b required %b", i, o_ready, e_ready);
      end
      checks++;
      if ({o_mv, o_mv0, o_mv1, o_maddr, o_msew, o_mop} !== {e_issue, e_mv0, e_mv1, e_maddr, e_msew, e_mop}) begin
        errors++;
        $display("FAIL random_fields[%0d]: got %b/%h required %b/%h", i, o_mv, o_mv0, e_issue, e_mv0);
      end
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL random_count: got %0d err=%b required %0d 0", got_q.size(), bus.err, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].id != exp_q[i].id || got_q[i].data !== exp_q[i].data || got_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL random_resp[%0d]: id=%0d data=%h required id=%0d data=%h", i, got_q[i].id, got_q[i].data, exp_q[i].id, exp_q[i].data);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin drive(2'b11); tick(); end
    #2;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    checks++;
    if ({bus.req_ready, bus.mul_valid, bus.resp_valid, bus.resp_id, bus.err} !== 6'b0 ||
        {bus.resp_data, bus.resp_addr, bus.mul_vec0, bus.mul_addr} !== '0) begin
      errors++;
      $display("FAIL async_reset: ctrl=%b data=%h required 0", {bus.req_ready, bus.mul_valid, bus.resp_valid, bus.err}, bus.resp_data);
    end
    @(negedge clk);
    idle_inputs();
    pipe_q.delete(); exp_q.delete(); got_q.delete();
    m_occ = 0; m_last = 1;
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    repeat (10) tick();
    checks++;
    if (bus.err !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_after: err=%b resp_valid=%b required 0 0", bus.err, bus.resp_valid);
    end
  endtask

`ifdef VMUL_ISSUE_CTRL_FLUSH_EN
  task automatic test_flush();
    do_reset();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(2'b01); tick(); end
    bus.req_valid = 2'b00;
    tick();
    fl = 1'b1;
    drive(2'b11);
    tick();
    fl = 1'b0;
    checks++;
    if (o_ready !== 2'b00 || o_mv !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: ready=%b mv=%b required 00 0", o_ready, o_mv);
    end
    bus.req_valid = 2'b00;
    repeat (12) tick();
    checks++;
    if (got_q.size() != 0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: responses=%0d err=%b required 0 0", got_q.size(), bus.err);
    end
    drive(2'b10);
    tick();
    drain();
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL flush_recover: responses=%0d err=%b required 1 0", got_q.size(), bus.err);
    end else begin
      checks++;
      if (got_q[0].id != 1 || got_q[0].data !== exp_q[0].data) begin
        errors++;
        $display("FAIL flush_recover_data: id=%0d data=%h required 1 %h", got_q[0].id, got_q[0].data, exp_q[0].data);
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_push_pop();
    test_random();
    test_async_reset();
`ifdef VMUL_ISSUE_CTRL_FLUSH_EN
    test_flush();
`endif
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
